mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one single-port data/instruction memory among NCORES processor cores.
- Each core's control unit raises a level request (read, write or instruction fetch) with address and write data.
- The arbiter grants one core at a time, drives the memory port, counts the fixed memory latency, returns read data and pulses a per-core done.
- Sits between the per-core controlUnit/datapath instances and the shared memory in the multicore top level.

Parameters:
NCORES, 4, number of requesting cores (2..8)
AW, 16, address width
DW, 16, data width
MEM_LAT, 2, memory read latency in clk cycles from the mem_en edge to valid mem_rdata (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
core_req  in  NCORES  per-core level request; held until done observed
core_wr  in  NCORES  per-core 1=write, 0=read/fetch
core_addr  in  NCORES*AW  packed; core i at [i*AW +: AW]
core_wdata  in  NCORES*DW  packed; core i at [i*DW +: DW]
core_gnt  out  NCORES  one-hot grant, held from grant edge through DONE
core_done  out  NCORES  one-hot one-cycle completion pulse
core_rdata  out  DW  read data, broadcast; valid while core_done is high
mem_en  out  1  memory access strobe, one cycle
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en edge

Behaviour:
- Reset values (async, rst_n=0): state IDLE; core_gnt=0, core_done=0, core_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; latency counter 0; last-grant pointer = NCORES-1, so core 0 wins first.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM: IDLE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If core_req != 0, select the first requesting core searching from (ptr+1) mod NCORES upward with wrap.
  - At that edge: core_gnt[sel]=1; mem_en=1; mem_we=core_wr[sel]; mem_addr and mem_wdata are latched from core sel; cnt=MEM_LAT; ptr=sel; go to WAIT.
  - If core_req == 0, stay in IDLE.
- WAIT:
  - mem_en and mem_we clear after one cycle.
  - mem_addr and mem_wdata hold their values until the next grant.
  - cnt decrements each edge.
  - At the edge where cnt==1: core_rdata=mem_rdata (captured for writes too; don't-care), core_done[sel]=1, go to DONE.
- DONE: one cycle. core_done and core_gnt clear at the exiting edge; go to IDLE. core_req is not sampled in DONE.
- Timing for a grant at edge E: done is high in the cycle after E+MEM_LAT, and the next grant is possible at E+MEM_LAT+2. Minimum access period is MEM_LAT+2 cycles.
- Requester protocol: the core registers req <= req & ~done, so req is low by the next IDLE sample and no spurious re-grant occurs. Back-to-back accesses from one core re-raise req after done.
- Fairness: the just-served core has lowest priority next round. With all NCORES requesting continuously, grants rotate 0,1,2,...,NCORES-1,0.
- Request dropped during WAIT: ignored. The transaction completes and done still pulses.
- Changes to core_addr, core_wdata or core_wr after the grant edge have no effect (values are latched).
- Reset asserted mid-transaction: the access is aborted with no done pulse, and all state returns to reset values immediately. Memory side effects of an already-issued write are not undone.
- Address/data widths pass through unchanged; no arithmetic beyond the counter and pointer. Counter width is clog2(MEM_LAT+1); pointer width is clog2(NCORES).

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - the default AW/DW localparams;
  - a function that computes clog2 widths.
- One sub-module, rr_pick: combinational round-robin select. Inputs are the req vector and ptr; outputs are the one-hot sel, the binary sel index and any_req. It is reusable for the planned bus/interrupt arbiters.
- Top module holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset with all inputs X then 0 → all outputs 0. First single request from core 2 (rd, addr 0x0040, mem_rdata 0xBEEF) → gnt=0100 one edge later, mem_en one cycle with addr 0x0040, done[2] with core_rdata 0xBEEF exactly MEM_LAT edges after the grant.
- Core 1 write (addr 0x0010, wdata 0x1234) → mem_en=1, mem_we=1, mem_addr 0x0010, mem_wdata 0x1234 for one cycle; done[1] pulses once.
- All four cores requesting continuously, each dropping req on done and re-raising one cycle later → grant order 0,1,2,3,0,1 with grants spaced MEM_LAT+2=4 cycles apart.
- Cores 0 and 3 request simultaneously from reset → core 0 granted first, then core 3. Next round with both requesting → core 0 again (ptr=3 wraps).
- Core 0 changes addr and drops req in the cycle after the grant → memory sees the original addr and done[0] still pulses. No grant while req is low.
- rst_n asserted in WAIT → gnt, mem_en and done go 0 asynchronously, with no done pulse. After release, a pending core 0 request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester after ptr wins, with wrap.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel_oh,
  output logic [PW-1:0] sel_idx,
  output logic          any_req
);

  // Scan positions ptr+1 .. ptr+N (mod N); the first hit is latched by any_req.
  always_comb begin
    int idx;
    idx     = 0;
    sel_oh  = '0;
    sel_idx = '0;
    any_req = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any_req && req[idx]) begin
        any_req     = 1'b1;
        sel_oh[idx] = 1'b1;
        sel_idx     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NCORES cores.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; sample core_req and grant on any request
// WAIT  | access issued; count down the fixed memory latency
// DONE  | done pulse visible for one cycle; grant released on exit
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCORES  = 4,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCORES-1:0] core_req,
  input  logic [NCORES-1:0] core_wr,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  output logic [NCORES-1:0] core_gnt,
  output logic [NCORES-1:0] core_done,
  output logic [DW-1:0]     core_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW = clog2_w(MEM_LAT + 1);
  localparam int PW = clog2_w(NCORES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Last-served pointer resets to the top core so core 0 wins the first round.
  localparam logic [PW-1:0] PTR_RST  = PW'(NCORES - 1);

  arb_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [NCORES-1:0] sel_oh;
  logic [PW-1:0]     sel_idx;
  logic              any_req;

  logic [NCORES-1:0] gnt_d, done_d;
  logic [DW-1:0]     rdata_d, wdata_d;
  logic [AW-1:0]     addr_d;
  logic              en_d, we_d;

  rr_pick #(.N(NCORES), .PW(PW)) u_pick (
    .req     (core_req),
    .ptr     (ptr_q),
    .sel_oh  (sel_oh),
    .sel_idx (sel_idx),
    .any_req (any_req)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: grant on any request, leave WAIT on the last latency count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = WAIT;
      WAIT:    if (cnt_q == CNT_ONE) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and pointer.
  always_comb begin
    gnt_d   = core_gnt;
    done_d  = '0;
    rdata_d = core_rdata;
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = sel_oh;
          en_d    = 1'b1;
          we_d    = core_wr[sel_idx];
          addr_d  = core_addr[int'(sel_idx)*AW +: AW];
          wdata_d = core_wdata[int'(sel_idx)*DW +: DW];
          cnt_d   = CNT_LOAD;
          ptr_d   = sel_idx;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        // Read data is captured for writes too; the requester ignores it.
        if (cnt_q == CNT_ONE) begin
          rdata_d = mem_rdata;
          done_d  = core_gnt;
        end
      end
      DONE:    gnt_d = '0;
      default: gnt_d = '0;
    endcase
  end

  // Output, counter and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_gnt   <= '0;
      core_done  <= '0;
      core_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cnt_q      <= '0;
      ptr_q      <= PTR_RST;
    end else begin
      core_gnt   <= gnt_d;
      core_done  <= done_d;
      core_rdata <= rdata_d;
      mem_en     <= en_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single accesses plus hand-written
// rotation, wrap, dropped-request and mid-access reset sequences.
module tb_mem_port_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NC-1:0]    core_req, core_wr;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [NC-1:0]    core_gnt, core_done;
  logic [DW-1:0]    core_rdata;
  logic             mem_en, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;

  typedef struct {
    int          core;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t vec[6];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] mem [0:255];
  int rem [NC];
  logic [NC-1:0] reraise;
  logic [NC-1:0] prev_gnt;
  int grant_cyc, last_grant;
  bit spacing_on, have_last;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_req   (core_req),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_done  (core_done),
    .core_rdata (core_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears only in the one cycle the arbiter samples it.
  always @(posedge clk) begin
    mem_rdata <= 16'hDEAD;
    if (mem_en === 1'b1) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  // Requester model: drop req on done, re-raise one cycle later while work remains.
  always @(negedge clk) begin
    if (!rst_n) reraise = '0;
    else begin
      for (int i = 0; i < NC; i++) begin
        if (core_done[i] === 1'b1) begin
          core_req[i] = 1'b0;
          if (rem[i] > 0) rem[i]--;
          reraise[i] = (rem[i] > 0);
        end else if (reraise[i]) begin
          core_req[i] = 1'b1;
          reraise[i] = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard: check issue at grant, pop and check at done.
  always @(negedge clk) begin
    logic rise;
    txn_t e;
    if (!rst_n) prev_gnt = '0;
    else begin
      rise = (prev_gnt == '0) && (core_gnt != '0);
      chk("mem_en_pulse", 32'(mem_en), 32'(rise));
      if (rise) begin
        if (exp_q.size() == 0) fail_msg($sformatf("unexpected_grant gnt=%b", core_gnt));
        else begin
          e = exp_q[0];
          chk("grant_onehot", 32'(core_gnt), 32'(1) << e.core);
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_we", 32'(mem_we), 32'(e.wr));
          if (e.wr) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          if (spacing_on && have_last) chk("grant_spacing", cyc - last_grant, LAT + 2);
          have_last  = 1'b1;
          last_grant = cyc;
          grant_cyc  = cyc;
        end
      end
      if (core_done != '0) begin
        if (exp_q.size() == 0) fail_msg($sformatf("unexpected_done done=%b", core_done));
        else begin
          e = exp_q.pop_front();
          chk("done_onehot", 32'(core_done), 32'(1) << e.core);
          chk("gnt_at_done", 32'(core_gnt), 32'(1) << e.core);
          chk("done_latency", cyc - grant_cyc, LAT);
          if (!e.wr) chk("core_rdata", 32'(core_rdata), 32'(e.rdata));
        end
      end
      prev_gnt = core_gnt;
    end
  end

  task automatic set_core(input int c, input logic wr, input logic [15:0] a, input logic [15:0] d);
    core_addr[c*AW +: AW]  = a;
    core_wdata[c*DW +: DW] = d;
    core_wr[c]             = wr;
  endtask

  task automatic push(input int c, input logic wr, input logic [15:0] a,
                      input logic [15:0] d, input logic [15:0] r);
    txn_t t;
    t.core = c; t.wr = wr; t.addr = a; t.wdata = d; t.rdata = r;
    exp_q.push_back(t);
  endtask

  task automatic do_reset();
    @(negedge clk);
    core_req = '0;
    rst_n = 1'b0;
    exp_q.delete();
    have_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || core_gnt != '0 || core_req != '0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_msg({nm, "_timeout"});
    @(negedge clk);
  endtask

  task automatic wait_gnt(input string nm);
    int n;
    n = 0;
    while (core_gnt == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (core_gnt == '0) fail_msg({nm, "_grant_timeout"});
  endtask

  initial begin
    logic [15:0] a16;
    int order [6];
    core_req   = 'x;
    core_wr    = 'x;
    core_addr  = 'x;
    core_wdata = 'x;
    spacing_on = 1'b0;
    have_last  = 1'b0;
    for (int i = 0; i < NC; i++) rem[i] = 0;
    for (int a = 0; a < 256; a++) mem[a] = {8'hC0, 8'(a)};
    mem[8'h40] = 16'hBEEF;
    mem[8'h41] = 16'h5A5A;

    vec[0] = '{core: 2, wr: 1'b0, addr: 16'h0040, wdata: 16'h0000, rdata: 16'hBEEF};
    vec[1] = '{core: 1, wr: 1'b1, addr: 16'h0010, wdata: 16'h1234, rdata: 16'h0000};
    vec[2] = '{core: 3, wr: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'h1234};
    vec[3] = '{core: 0, wr: 1'b1, addr: 16'h00FF, wdata: 16'hAAAA, rdata: 16'h0000};
    vec[4] = '{core: 0, wr: 1'b0, addr: 16'h00FF, wdata: 16'h0000, rdata: 16'hAAAA};
    vec[5] = '{core: 1, wr: 1'b0, addr: 16'h0041, wdata: 16'h0000, rdata: 16'h5A5A};

    // Reset with inputs unknown.
    #2 rst_n = 1'b0;
    #2;
    chk("rst_gnt",   32'(core_gnt),   0);
    chk("rst_done",  32'(core_done),  0);
    chk("rst_rdata", 32'(core_rdata), 0);
    chk("rst_en",    32'(mem_en),     0);
    chk("rst_we",    32'(mem_we),     0);
    chk("rst_addr",  32'(mem_addr),   0);
    chk("rst_wdata", 32'(mem_wdata),  0);
    core_req = '0; core_wr = '0; core_addr = '0; core_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single accesses from the table.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      set_core(vec[v].core, vec[v].wr, vec[v].addr, vec[v].wdata);
      rem[vec[v].core] = 1;
      exp_q.push_back(vec[v]);
      core_req[vec[v].core] = 1'b1;
      wait_idle("vector");
    end

    // All cores requesting continuously: rotation 0,1,2,3,0,1 spaced LAT+2.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      a16 = 16'(32'h20 + i);
      set_core(i, 1'b0, a16, 16'h0);
    end
    rem[0] = 2; rem[1] = 2; rem[2] = 1; rem[3] = 1;
    order = '{0, 1, 2, 3, 0, 1};
    for (int k = 0; k < 6; k++) begin
      a16 = 16'(32'h20 + order[k]);
      push(order[k], 1'b0, a16, 16'h0, {8'hC0, a16[7:0]});
    end
    spacing_on = 1'b1;
    have_last  = 1'b0;
    core_req   = '1;
    wait_idle("rotation");
    spacing_on = 1'b0;

    // Cores 0 and 3 together from reset: 0,3 then 0 again after the pointer wraps.
    do_reset();
    @(negedge clk);
    set_core(0, 1'b0, 16'h0050, 16'h0);
    set_core(3, 1'b0, 16'h0053, 16'h0);
    rem[0] = 2; rem[3] = 2;
    push(0, 1'b0, 16'h0050, 16'h0, 16'hC050);
    push(3, 1'b0, 16'h0053, 16'h0, 16'hC053);
    push(0, 1'b0, 16'h0050, 16'h0, 16'hC050);
    push(3, 1'b0, 16'h0053, 16'h0, 16'hC053);
    core_req = 4'b1001;
    wait_idle("wrap");

    // Request dropped and address changed right after the grant.
    @(negedge clk);
    rem[0] = 0;
    set_core(0, 1'b0, 16'h0030, 16'h0);
    push(0, 1'b0, 16'h0030, 16'h0, 16'hC030);
    core_req[0] = 1'b1;
    wait_gnt("drop");
    set_core(0, 1'b1, 16'h0077, 16'h5555);
    core_req[0] = 1'b0;
    @(negedge clk);
    chk("addr_latched", 32'(mem_addr), 32'h0030);
    chk("we_latched", 32'(mem_we), 0);
    wait_idle("drop");
    repeat (6) @(negedge clk);
    chk("no_regrant", 32'(core_gnt), 0);

    // Reset while waiting on memory: aborted with no done, then a normal grant.
    set_core(0, 1'b0, 16'h0031, 16'h0);
    rem[0] = 1;
    push(0, 1'b0, 16'h0031, 16'h0, 16'hC031);
    core_req[0] = 1'b1;
    wait_gnt("abort");
    #2 rst_n = 1'b0;
    #1;
    chk("abort_gnt",  32'(core_gnt),  0);
    chk("abort_en",   32'(mem_en),    0);
    chk("abort_done", 32'(core_done), 0);
    exp_q.delete();
    have_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("done_in_reset", 32'(core_done), 0);
    end
    push(0, 1'b0, 16'h0031, 16'h0, 16'hC031);
    rst_n = 1'b1;
    wait_idle("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
